fetch_control: RTL and testbench

Instruction-fetch control stage that sits directly upstream of the program counter register and owns the IF/ID pipeline latch. Each cycle it computes the PC's `next_pc` and `hold_pc` inputs from the run state, load-use stalls, branch/jump redirects and debug step requests. It captures the fetched instruction and PC+4 into IF/ID, and it stops fetching when a HALT word is fetched.

---
 rtl/fetch_control_if.sv | 32 +++
 rtl/fetch_control.sv | 118 +++++++++++
 tb/tb_fetch_control.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_control_if.sv
// Bundle between the fetch control stage and its neighbours (PC register, imem, hazard unit, IF/ID consumer).
interface fetch_control_if #(
  parameter int unsigned MSB = 32
);
  logic [MSB-1:0] i_pc;
  logic [MSB-1:0] i_instr;
  logic           i_run;
  logic           i_mode_step;
  logic           i_step;
  logic           i_stall;
  logic           i_redirect;
  logic [MSB-1:0] i_redirect_target;
  logic [MSB-1:0] o_next_pc;
  logic           o_hold_pc;
  logic [MSB-1:0] o_instr_id;
  logic [MSB-1:0] o_pc4_id;
  logic           o_valid_id;
  logic           o_halted;
  logic [31:0]    o_fetch_count;

  // Environment side: drives PC, instruction and control requests.
  modport master (
    output i_pc, i_instr, i_run, i_mode_step, i_step, i_stall, i_redirect, i_redirect_target,
    input  o_next_pc, o_hold_pc, o_instr_id, o_pc4_id, o_valid_id, o_halted, o_fetch_count
  );

  // Fetch control side.
  modport slave (
    input  i_pc, i_instr, i_run, i_mode_step, i_step, i_stall, i_redirect, i_redirect_target,
    output o_next_pc, o_hold_pc, o_instr_id, o_pc4_id, o_valid_id, o_halted, o_fetch_count
  );
endinterface

// File: rtl/fetch_control.sv
// Instruction-fetch control: drives PC next/hold, owns the IF/ID latch and stops on a HALT word.
// Optional macro FETCH_COUNT_EN builds the fetched-instruction counter; otherwise it reads 0.
module fetch_control #(
  parameter int unsigned    MSB       = 32,
  parameter logic [MSB-1:0] HALT_WORD = MSB'(32'hFFFF_FFFF),
  parameter logic [MSB-1:0] NOP_WORD  = MSB'(32'h0000_0000)
) (
  input logic             i_clk,
  input logic             i_rst,
  fetch_control_if.slave  bus
);

  localparam int unsigned CNT_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]     state, state_nx;
  logic           pend, pend_nx;
  logic [MSB-1:0] instr_q, instr_nx;
  logic [MSB-1:0] pc4_q, pc4_nx;
  logic           valid_q, valid_nx;
  logic           halted_q, halted_nx;
  logic           advance;
  logic           halt_cap;
  logic [MSB-1:0] pc_plus4;

  assign pc_plus4 = bus.i_pc + MSB'(4);

  // Next-state, advance decision and IF/ID next values.
  always_comb begin
    state_nx  = state;
    pend_nx   = 1'b0;
    instr_nx  = NOP_WORD;
    pc4_nx    = pc4_q;
    valid_nx  = 1'b0;
    halted_nx = halted_q;
    advance   = 1'b0;
    halt_cap  = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.i_run) state_nx = bus.i_mode_step ? S_STEP : S_RUN;
      end
      S_RUN: begin
        advance = !bus.i_stall || bus.i_redirect;
      end
      S_STEP: begin
        // A redirect only counts once a step is pending; a second step while pending is dropped.
        advance = pend && (!bus.i_stall || bus.i_redirect);
        pend_nx = pend ? !advance : bus.i_step;
      end
      default: ;
    endcase

    halt_cap = advance && !bus.i_redirect && (bus.i_instr == HALT_WORD);

    if (advance) begin
      pc4_nx = pc_plus4;
      if (!bus.i_redirect) begin
        instr_nx = bus.i_instr;
        valid_nx = 1'b1;
      end
    end else if (state == S_RUN || (state == S_STEP && pend)) begin
      // Stalled fetch: IF/ID keeps its entry.
      instr_nx = instr_q;
      valid_nx = valid_q;
    end

    if (halt_cap) begin
      state_nx  = S_HALT;
      halted_nx = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      pend     <= 1'b0;
      instr_q  <= NOP_WORD;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state    <= state_nx;
      pend     <= pend_nx;
      instr_q  <= instr_nx;
      pc4_q    <= pc4_nx;
      valid_q  <= valid_nx;
      halted_q <= halted_nx;
    end
  end

  // PC control is combinational so the PC register updates on the next edge.
  assign bus.o_next_pc  = bus.i_redirect ? bus.i_redirect_target : pc_plus4;
  assign bus.o_hold_pc  = !advance || halt_cap;
  assign bus.o_instr_id = instr_q;
  assign bus.o_pc4_id   = pc4_q;
  assign bus.o_valid_id = valid_q;
  assign bus.o_halted   = halted_q;

`ifdef FETCH_COUNT_EN
  logic [CNT_W-1:0] count_q;

  // Counts every valid IF/ID capture, the HALT word included.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                           count_q <= '0;
    else if (advance && !bus.i_redirect) count_q <= count_q + CNT_W'(1);
  end

  assign bus.o_fetch_count = count_q;
`else
  assign bus.o_fetch_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_fetch_control.sv
// Scoreboard bench for fetch_control: directed test-plan sequences plus random phases vs. a behavioural model.
module tb_fetch_control;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0000;
`ifdef FETCH_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_reg = 32'd0;
  logic [31:0] mem [64];

  fetch_control_if #(.MSB(32)) bus ();

  fetch_control #(.MSB(32), .HALT_WORD(HALT), .NOP_WORD(NOP)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Program counter register and instruction memory of the surrounding datapath.
  always @(posedge clk or posedge rst) begin
    if (rst)                 pc_reg <= 32'd0;
    else if (!bus.o_hold_pc) pc_reg <= bus.o_next_pc;
  end
  assign bus.i_pc    = pc_reg;
  assign bus.i_instr = mem[pc_reg[7:2]];

  typedef struct {
    logic [31:0] next_pc;
    logic        hold;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    logic [31:0] count;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: what the fetch stage has done so far, in plain terms.
  bit          started, step_mode, halted, pending;
  logic [31:0] id_instr, id_pc4, mpc;
  bit          id_valid;
  int unsigned fetched;

  task automatic model(input bit r, run, mode, step, stall, redir, input logic [31:0] tgt);
    exp_t        e;
    bit          go;
    bit          hits_halt;
    logic [31:0] word;
    logic [31:0] seq;
    if (r) begin
      started = 0; step_mode = 0; halted = 0; pending = 0;
      id_instr = NOP; id_pc4 = 32'd0; id_valid = 0; fetched = 0; mpc = 32'd0;
    end
    go = 0;
    if (started && !halted)
      go = step_mode ? (pending && (!stall || redir)) : (!stall || redir);
    word      = mem[mpc[7:2]];
    seq       = mpc + 32'd4;
    hits_halt = go && !redir && (word == HALT);
    e.next_pc = redir ? tgt : seq;
    e.hold    = !go || hits_halt;
    e.instr   = id_instr;
    e.pc4     = id_pc4;
    e.valid   = id_valid;
    e.halted  = halted;
    e.count   = COUNT_EN ? 32'(fetched) : 32'd0;
    e.pc      = mpc;
    q.push_back(e);
    if (r) return;

    if (go) begin
      id_pc4 = seq;
      if (redir) begin
        id_instr = NOP; id_valid = 0;
      end else begin
        id_instr = word; id_valid = 1; fetched++;
      end
    end else if (!(started && !halted && (!step_mode || pending))) begin
      id_instr = NOP; id_valid = 0;
    end
    if (started && step_mode && !halted) pending = pending ? !go : step;
    else                                 pending = 0;
    if (hits_halt) halted = 1;
    if (!started && run) begin
      started = 1; step_mode = mode;
    end
    if (!e.hold) mpc = e.next_pc;
  endtask

  task automatic cycle(input bit r, run, mode, step, stall, redir, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    rst                   = r;
    bus.i_run             = run;
    bus.i_mode_step       = mode;
    bus.i_step            = step;
    bus.i_stall           = stall;
    bus.i_redirect        = redir;
    bus.i_redirect_target = tgt;
    model(r, run, mode, step, stall, redir, tgt);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: compare every output against the queued expectation mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc",          bus.i_pc,            e.pc);
      chk("next_pc",     bus.o_next_pc,       e.next_pc);
      chk("hold_pc",     32'(bus.o_hold_pc),  32'(e.hold));
      chk("instr_id",    bus.o_instr_id,      e.instr);
      chk("pc4_id",      bus.o_pc4_id,        e.pc4);
      chk("valid_id",    32'(bus.o_valid_id), 32'(e.valid));
      chk("halted",      32'(bus.o_halted),   32'(e.halted));
      chk("fetch_count", bus.o_fetch_count,   e.count);
    end
  end

  task automatic load_prog(input int halt_idx);
    for (int i = 0; i < 64; i++) mem[i] = NOP;
    mem[halt_idx] = HALT;
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0, 0, 32'd0);
    cycle(1, 0, 0, 0, 0, 0, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 32'd0);
  endtask

  initial begin
    bus.i_run = 0; bus.i_mode_step = 0; bus.i_step = 0;
    bus.i_stall = 0; bus.i_redirect = 0; bus.i_redirect_target = 32'd0;

    // Three NOPs then HALT at 0xC.
    load_prog(3);
    do_reset();
    cycle(0, 1, 0, 0, 0, 0, 32'd0);
    idle(8);

    // Stall at PC=8, redirect over stall, redirect to the top word then wrap.
    load_prog(40);
    do_reset();
    cycle(0, 1, 0, 0, 0, 0, 32'd0);
    idle(2);
    cycle(0, 0, 0, 0, 1, 0, 32'd0);
    cycle(0, 0, 0, 0, 1, 0, 32'd0);
    idle(2);
    cycle(0, 0, 0, 0, 1, 1, 32'h40);
    idle(2);
    cycle(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    idle(3);

    // Step mode: three step pulses five cycles apart, then a stalled step.
    do_reset();
    cycle(0, 1, 1, 0, 0, 0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 1, 0, 0, 32'd0);
      idle(4);
    end
    cycle(0, 0, 0, 1, 1, 0, 32'd0);
    cycle(0, 0, 0, 1, 1, 0, 32'd0);
    idle(3);

    // Reset mid-run at PC=0x20, then stay idle before restarting.
    do_reset();
    cycle(0, 1, 0, 0, 0, 0, 32'd0);
    idle(8);
    do_reset();
    idle(3);
    cycle(0, 1, 0, 0, 0, 0, 32'd0);
    idle(3);

    // Random phases: random programs, modes, stalls, redirects, steps and resets.
    for (int p = 0; p < 14; p++) begin
      for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 2) == 0) ? $urandom : NOP;
      mem[$urandom_range(8, 63)] = HALT;
      do_reset();
      cycle(0, 1, 1'($urandom_range(0, 1)), 0, 0, 0, 32'd0);
      for (int c = 0; c < 80; c++) begin
        bit          r, run, redir;
        logic [31:0] tgt;
        r     = (p % 3 == 0) && (c == 40 || c == 41);
        run   = ((p % 3 == 0) && c == 43) || ($urandom_range(0, 15) == 0);
        redir = ($urandom_range(0, 7) == 0);
        tgt   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 63)) << 2;
        cycle(r, run, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), redir, tgt);
      end
    end

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
